// File: rtl/mux81_scan_ctrl.sv
// Sequential scanner for an 8-to-1 mux: steps the select lines, samples Y into an 8-bit word, and returns it over valid/ready.
// Optional Y/W complement checker enabled by defining MUX81_SCAN_CHECK_EN.
module mux81_scan_ctrl #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  output logic [2:0] o_sel,
  output logic       o_enb,
  input  logic       i_y_in,
  input  logic       i_w_in,
  output logic [7:0] o_word,
  output logic       o_word_valid,
  input  logic       i_word_ready,
  output logic       o_busy,
  output logic       o_err,
  output logic [7:0] o_err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LP_SETTLE_LAST = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);
  // With no settle time every channel goes straight to its sample cycle.
  localparam state_t LP_FIRST = (SETTLE_CYC == 0) ? S_SAMPLE : S_SETTLE;

  state_t     r_state;
  logic [2:0] r_sel;
  logic [3:0] r_cnt;
  logic [7:0] r_word;

  state_t     w_state_next;
  logic [2:0] w_sel_next;
  logic [3:0] w_cnt_next;
  logic [7:0] w_word_next;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned, which would infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_cnt_next   = r_cnt;
    w_word_next  = r_word;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = LP_FIRST;
          w_sel_next   = 3'd0;
          w_cnt_next   = 4'd0;
        end
      end
      S_SETTLE: begin
        if (r_cnt == LP_SETTLE_LAST) begin
          w_state_next = S_SAMPLE;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      S_SAMPLE: begin
        w_word_next[r_sel] = i_y_in;
        if (r_sel != 3'd7) begin
          w_sel_next   = r_sel + 3'd1;
          w_state_next = LP_FIRST;
        end else begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (i_word_ready) begin
          w_sel_next   = 3'd0;
          w_cnt_next   = 4'd0;
          w_state_next = i_start ? LP_FIRST : S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_sel   <= 3'd0;
      r_cnt   <= 4'd0;
      r_word  <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      r_cnt   <= w_cnt_next;
      r_word  <= w_word_next;
    end
  end

  // Outputs decode straight from state so reset drives them without waiting for an edge.
  assign o_sel        = r_sel;
  assign o_word       = r_word;
  assign o_enb        = (r_state == S_IDLE) || (r_state == S_DONE);
  assign o_word_valid = (r_state == S_DONE);
  assign o_busy       = (r_state != S_IDLE);

`ifdef MUX81_SCAN_CHECK_EN
  logic       r_err;
  logic [7:0] r_err_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else if ((r_state == S_SAMPLE) && (i_y_in !== ~i_w_in)) begin
      r_err <= 1'b1;
      if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end else begin
      r_err <= 1'b0;
    end
  end

  assign o_err     = r_err;
  assign o_err_cnt = r_err_cnt;
`else
  logic w_unused_w_in;
  assign w_unused_w_in = i_w_in;
  assign o_err         = 1'b0;
  assign o_err_cnt     = 8'd0;
`endif

endmodule

// File: tb/tb_mux81_scan_ctrl.sv
// Directed bench for mux81_scan_ctrl: two instances (SETTLE_CYC=1 and 0), each wired to a behavioural MUX81.
// Expected err values follow whether MUX81_SCAN_CHECK_EN is defined for the build.
module tb_mux81_scan_ctrl;

`ifdef MUX81_SCAN_CHECK_EN
  localparam logic [7:0] EXP_ERR_PULSE = 8'd1;
`else
  localparam logic [7:0] EXP_ERR_PULSE = 8'd0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checks = 0;
  int         failures = 0;

  // Instance with SETTLE_CYC=1
  logic       start = 1'b0, ready = 1'b0, force_eq = 1'b0;
  logic [7:0] data = 8'h00;
  logic [2:0] sel;
  logic       enb, y, w, valid, busy, err;
  logic [7:0] word, err_cnt;

  // Instance with SETTLE_CYC=0
  logic       start0 = 1'b0, ready0 = 1'b0;
  logic [7:0] data0 = 8'h00;
  logic [2:0] sel0;
  logic       enb0, y0, w0, valid0, busy0, err0;
  logic [7:0] word0, err_cnt0;

  always #5 clk = ~clk;

  assign y  = enb ? 1'b0 : data[sel];
  assign w  = force_eq ? y : ~y;
  assign y0 = enb0 ? 1'b0 : data0[sel0];
  assign w0 = ~y0;

  mux81_scan_ctrl #(.SETTLE_CYC(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_sel(sel), .o_enb(enb),
    .i_y_in(y), .i_w_in(w), .o_word(word), .o_word_valid(valid),
    .i_word_ready(ready), .o_busy(busy), .o_err(err), .o_err_cnt(err_cnt)
  );

  mux81_scan_ctrl #(.SETTLE_CYC(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .o_sel(sel0), .o_enb(enb0),
    .i_y_in(y0), .i_w_in(w0), .o_word(word0), .o_word_valid(valid0),
    .i_word_ready(ready0), .o_busy(busy0), .o_err(err0), .o_err_cnt(err_cnt0)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset values
    #2;
    check("rst_sel", 8'(sel), 8'd0);
    check("rst_enb", 8'(enb), 8'd1);
    check("rst_word", word, 8'h00);
    check("rst_valid", 8'(valid), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_err", 8'(err), 8'd0);
    check("rst_err_cnt", err_cnt, 8'd0);
    tick();
    rst = 1'b0;

    // Scan A5 with SETTLE_CYC=1: sel visits 0..7, two cycles each, enb low 16 cycles
    data  = 8'hA5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      check($sformatf("scan_sel_c%0d", c), 8'(sel), 8'(c >> 1));
      check($sformatf("scan_enb_c%0d", c), 8'(enb), 8'd0);
      check($sformatf("scan_valid_c%0d", c), 8'(valid), 8'd0);
      tick();
    end
    check("scan_valid", 8'(valid), 8'd1);
    check("scan_word", word, 8'hA5);
    check("scan_enb_done", 8'(enb), 8'd1);
    check("scan_sel_done", 8'(sel), 8'd7);
    check("scan_busy_done", 8'(busy), 8'd1);
    check("scan_err_cnt", err_cnt, 8'd0);

    // Backpressure: word held, start ignored while ready is low
    data = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      start = (c == 3);
      tick();
      check($sformatf("bp_valid_c%0d", c), 8'(valid), 8'd1);
      check($sformatf("bp_word_c%0d", c), word, 8'hA5);
      check($sformatf("bp_enb_c%0d", c), 8'(enb), 8'd1);
    end
    start = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("hs_valid", 8'(valid), 8'd0);
    check("hs_busy", 8'(busy), 8'd0);
    check("hs_sel", 8'(sel), 8'd0);
    tick();
    check("hs_idle_enb", 8'(enb), 8'd1);
    check("hs_idle_busy", 8'(busy), 8'd0);

    // Continuous scans: words 01 then 80, 17 cycles apart
    data  = 8'h01;
    start = 1'b1;
    ready = 1'b1;
    tick();
    tick_n(16);
    check("cont1_valid", 8'(valid), 8'd1);
    check("cont1_word", word, 8'h01);
    data = 8'h80;
    tick();
    check("cont_restart_valid", 8'(valid), 8'd0);
    check("cont_restart_enb", 8'(enb), 8'd0);
    check("cont_restart_sel", 8'(sel), 8'd0);
    tick_n(15);
    check("cont2_early_valid", 8'(valid), 8'd0);
    tick();
    check("cont2_valid", 8'(valid), 8'd1);
    check("cont2_word", word, 8'h80);
    start = 1'b0;
    tick();
    ready = 1'b0;
    check("cont_end_busy", 8'(busy), 8'd0);

    // Asynchronous reset during SETTLE of channel 4
    data  = 8'h5A;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick_n(8);
    check("mid_sel", 8'(sel), 8'd4);
    check("mid_word_partial", word, 8'h8A);
    #2;
    rst = 1'b1;
    #1;
    check("arst_enb", 8'(enb), 8'd1);
    check("arst_sel", 8'(sel), 8'd0);
    check("arst_word", word, 8'h00);
    check("arst_busy", 8'(busy), 8'd0);
    check("arst_valid", 8'(valid), 8'd0);
    tick();
    data  = 8'hC3;
    start = 1'b1;
    rst   = 1'b0;
    tick();
    start = 1'b0;
    check("rel_busy", 8'(busy), 8'd1);
    check("rel_enb", 8'(enb), 8'd0);
    tick_n(16);
    check("rel_valid", 8'(valid), 8'd1);
    check("rel_word", word, 8'hC3);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    // Complement check: W forced equal to Y during channel 3 only
    data  = 8'h96;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick_n(6);
    force_eq = 1'b1;
    tick_n(2);
    force_eq = 1'b0;
    check("chk_err_pulse", 8'(err), EXP_ERR_PULSE);
    tick();
    check("chk_err_clear", 8'(err), 8'd0);
    tick_n(7);
    check("chk_valid", 8'(valid), 8'd1);
    check("chk_word", word, 8'h96);
    check("chk_err_cnt", err_cnt, EXP_ERR_PULSE);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    // SETTLE_CYC=0 instance: sel changes every cycle, word after 8 cycles
    data0  = 8'h3C;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check($sformatf("z_sel_c%0d", c), 8'(sel0), 8'(c));
      check($sformatf("z_enb_c%0d", c), 8'(enb0), 8'd0);
      tick();
    end
    check("z_valid", 8'(valid0), 8'd1);
    check("z_word", word0, 8'h3C);
    check("z_err_cnt", err_cnt0, 8'd0);
    ready0 = 1'b1;
    tick();
    ready0 = 1'b0;
    check("z_hs_valid", 8'(valid0), 8'd0);
    check("z_hs_busy", 8'(busy0), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
